// File: rtl/systolic_row_acc.sv
// Row of S multiply-accumulate lanes with a flush/drain controller and a serial ready/valid result port.
// Define SYSROW_SAT_EN to make accumulators clamp at 2^M-1; otherwise they wrap modulo 2^M.
module systolic_row_acc #(
  parameter int N = 8,
  parameter int M = 20,
  parameter int S = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   a_in,
  input  logic           a_valid,
  input  logic           sn,
  input  logic [S*N-1:0] b_in,
  input  logic           drain,
  output logic [M-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   a_out,
  output logic           a_valid_out,
  output logic [S*N-1:0] b_out,
  output logic           busy
);

  localparam int CW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          clear_acc;
  logic          accept;

  logic [S-1:0][N-1:0] a_pipe_q;
  logic [S-1:0]        v_pipe_q;
  logic [S-1:0]        f_pipe_q;
  logic [S-1:0][M-1:0] acc_q;
  logic [S-1:0][M-1:0] acc_d;
  logic [S*N-1:0]      b_out_q;

  logic [S-1:0][N-1:0] lane_a;
  logic [S-1:0]        lane_v;
  logic [S-1:0]        lane_f;

  // New operands only enter lane 0 while idle; in-flight ones keep rippling during the flush.
  assign accept = (state_q == ST_IDLE);

  generate
    for (genvar gi = 0; gi < S; gi++) begin : g_lane
      logic [2*N-1:0] prod;
      logic [M-1:0]   base;

      if (gi == 0) begin : g_head
        assign lane_a[gi] = a_in;
        assign lane_v[gi] = a_valid & accept;
        assign lane_f[gi] = sn & a_valid & accept;
      end else begin : g_body
        assign lane_a[gi] = a_pipe_q[gi-1];
        assign lane_v[gi] = v_pipe_q[gi-1];
        assign lane_f[gi] = f_pipe_q[gi-1];
      end

      assign prod = lane_a[gi] * b_in[gi*N +: N];
      assign base = lane_f[gi] ? '0 : acc_q[gi];

`ifdef SYSROW_SAT_EN
      logic [M:0] sum;
      assign sum        = {1'b0, base} + (M+1)'(prod);
      assign acc_d[gi]  = sum[M] ? {M{1'b1}} : sum[M-1:0];
`else
      assign acc_d[gi]  = base + M'(prod);
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      b_out_q  <= '0;
      a_pipe_q <= '0;
      v_pipe_q <= '0;
      f_pipe_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      b_out_q  <= b_in;
      a_pipe_q <= lane_a;
      v_pipe_q <= lane_v;
      f_pipe_q <= lane_f;
      for (int i = 0; i < S; i++) begin
        if (clear_acc) begin
          acc_q[i] <= '0;
        end else if (lane_v[i]) begin
          acc_q[i] <= acc_d[i];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    clear_acc = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (drain) begin
          state_d = ST_FLUSH;
          cnt_d   = CW'(S-1);
        end
      end
      ST_FLUSH: begin
        // S-1 cycles lets the last accepted operand reach lane S-1.
        if (cnt_q == '0) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_q == CW'(S-1)) begin
            clear_acc = 1'b1;
            idx_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_data    = (state_q == ST_DRAIN) ? acc_q[idx_q] : '0;
  assign busy        = (state_q != ST_IDLE);
  assign a_out       = a_pipe_q[S-1];
  assign a_valid_out = v_pipe_q[S-1];
  assign b_out       = b_out_q;

endmodule

// File: tb/tb_systolic_row_acc.sv
// Scoreboard bench for systolic_row_acc (N=8, M=20, S=4): expected results are queued
// when the drain is issued and popped on each output handshake.
module tb_systolic_row_acc;
  localparam int N = 8;
  localparam int M = 20;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   a_in;
  logic           a_valid;
  logic           sn;
  logic [S*N-1:0] b_in;
  logic           drain;
  logic [M-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   a_out;
  logic           a_valid_out;
  logic [S*N-1:0] b_out;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [M-1:0] exp_q[$];
  logic [N-1:0] feed_q[$];

  always #5 clk = ~clk;

  systolic_row_acc #(.N(N), .M(M), .S(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_in       (a_in),
    .a_valid    (a_valid),
    .sn         (sn),
    .b_in       (b_in),
    .drain      (drain),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_out      (a_out),
    .a_valid_out(a_valid_out),
    .b_out      (b_out),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_b(input logic [N-1:0] b0, input logic [N-1:0] b1,
                       input logic [N-1:0] b2, input logic [N-1:0] b3);
    b_in = {b3, b2, b1, b0};
  endtask

  // Feeds every byte in feed_q, tagging the first with sn.
  task automatic feed();
    int k = 0;
    while (feed_q.size() > 0) begin
      a_in    = feed_q.pop_front();
      a_valid = 1'b1;
      sn      = (k == 0);
      k++;
      step();
    end
    a_valid = 1'b0;
    sn      = 1'b0;
    a_in    = '0;
  endtask

  // Pulses drain and waits for the first out_valid; optionally injects A during the flush.
  task automatic do_drain(input bit inject);
    int cnt = 0;
    drain = 1'b1;
    step();
    drain = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_busy: got %0b, expected 1", busy);
    end
    if (inject) begin
      a_valid = 1'b1;
      a_in    = 8'd99;
      sn      = 1'b1;
    end
    while (!out_valid && cnt < 50) begin
      step();
      cnt++;
    end
    a_valid = 1'b0;
    a_in    = '0;
    sn      = 1'b0;
    n_checks++;
    if (cnt != S) begin
      n_fail++;
      $display("FAIL drain_latency: got %0d cycles, expected %0d", cnt, S);
    end
  endtask

  // Collects n results; mode 1 drives out_ready as 1,0,0 repeating.
  task automatic collect(input int n, input int mode, input bit pulse_drain);
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [M-1:0] held = '0;
    logic [M-1:0] e;
    while (got < n && cyc < 200) begin
      out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      drain     = pulse_drain && (cyc == 1);
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          n_fail++;
          $display("FAIL hold_stable: got valid=%0b data=%0d, expected valid=1 data=%0d",
                   out_valid, out_data, held);
        end
      end
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_result: got %0d, expected none", out_data);
          end else begin
            e = exp_q.pop_front();
            $display("result %0d: data %0d expected %0d", got, out_data, e);
            if (out_data !== e) begin
              n_fail++;
              $display("FAIL result_%0d: got %0d, expected %0d", got, out_data, e);
            end
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_data;
        end
      end
      step();
      cyc++;
    end
    drain     = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (got != n) begin
      n_fail++;
      $display("FAIL collect_count: got %0d results, expected %0d", got, n);
    end
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL end_idle: got busy=%0b valid=%0b, expected 0 0", busy, out_valid);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: got %0d pending, expected 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    n_checks++;
    if (out_data !== '0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        a_out !== '0 || a_valid_out !== 1'b0 || b_out !== '0) begin
      n_fail++;
      $display("FAIL %s: got data=%0d valid=%0b busy=%0b a_out=%0d av=%0b b_out=%h, expected all 0",
               tag, out_data, out_valid, busy, a_out, a_valid_out, b_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    check_reset_outputs("reset_initial");
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_mac();
    set_b(8'd1, 8'd2, 8'd3, 8'd4);
    feed_q = '{8'd1, 8'd2, 8'd3};
    feed();
    for (int i = 0; i < S; i++) exp_q.push_back(M'(6 * (i + 1)));
    do_drain(1'b0);
    collect(S, 0, 1'b0);
  endtask

  task automatic test_restart();
    set_b(8'd1, 8'd1, 8'd1, 8'd1);
    feed_q = '{8'd5};
    feed();
    for (int i = 0; i < S; i++) exp_q.push_back(M'(5));
    do_drain(1'b0);
    collect(S, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    set_b(8'd1, 8'd2, 8'd3, 8'd4);
    feed_q = '{8'd7, 8'd2};
    feed();
    for (int i = 0; i < S; i++) exp_q.push_back(M'(9 * (i + 1)));
    do_drain(1'b0);
    collect(S, 1, 1'b0);
  endtask

  task automatic test_overflow();
    logic [M-1:0] e;
`ifdef SYSROW_SAT_EN
    e = 20'd1048575;
`else
    e = 20'd56849;
`endif
    set_b(8'd255, 8'd255, 8'd255, 8'd255);
    for (int k = 0; k < 17; k++) feed_q.push_back(8'd255);
    feed();
    for (int i = 0; i < S; i++) exp_q.push_back(e);
    do_drain(1'b0);
    collect(S, 0, 1'b0);
  endtask

  task automatic test_ignore_rules();
    set_b(8'd2, 8'd3, 8'd4, 8'd5);
    feed_q = '{8'd3, 8'd4};
    feed();
    for (int i = 0; i < S; i++) exp_q.push_back(M'(7 * (i + 2)));
    do_drain(1'b1);
    collect(S, 0, 1'b1);
  endtask

  task automatic test_chaining();
    localparam int L = 12;
    localparam int T = L + S;
    logic [N-1:0]   hist_a  [T];
    logic           hist_v  [T];
    logic           hist_sn [T];
    logic [S*N-1:0] hist_b  [T];
    longint         m [S];
    bit             seen_valid = 1'b0;
    int             k;
    for (int i = 0; i < S; i++) m[i] = 0;
    for (int j = 0; j < T; j++) begin
      if (j >= S) begin
        n_checks++;
        if (a_out !== hist_a[j-S] || a_valid_out !== hist_v[j-S]) begin
          n_fail++;
          $display("FAIL chain_a_%0d: got %0d/%0b, expected %0d/%0b",
                   j, a_out, a_valid_out, hist_a[j-S], hist_v[j-S]);
        end
      end
      if (j >= 1) begin
        n_checks++;
        if (b_out !== hist_b[j-1]) begin
          n_fail++;
          $display("FAIL chain_b_%0d: got %h, expected %h", j, b_out, hist_b[j-1]);
        end
      end
      hist_a[j]  = N'($urandom_range(0, 255));
      hist_v[j]  = (j < L) ? ((j == 0) || ($urandom_range(0, 1) == 1)) : 1'b0;
      hist_sn[j] = (hist_v[j] && !seen_valid) ? 1'b1 : ($urandom_range(0, 3) == 0);
      if (hist_v[j]) seen_valid = 1'b1;
      hist_b[j]  = (S*N)'({$urandom, $urandom});
      a_in    = hist_a[j];
      a_valid = hist_v[j];
      sn      = hist_sn[j];
      b_in    = hist_b[j];
      for (int i = 0; i < S; i++) begin
        k = j - i;
        if (k >= 0 && hist_v[k])
          m[i] = (hist_sn[k] ? 0 : m[i]) + longint'(hist_a[k]) * longint'(hist_b[j][i*N +: N]);
      end
      step();
    end
    a_valid = 1'b0;
    sn      = 1'b0;
    a_in    = '0;
    for (int i = 0; i < S; i++) exp_q.push_back(M'(m[i]));
    do_drain(1'b0);
    collect(S, 0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    set_b(8'd1, 8'd1, 8'd1, 8'd1);
    feed_q = '{8'd5};
    feed();
    do_drain(1'b0);
    n_checks++;
    if (out_data !== 20'd5) begin
      n_fail++;
      $display("FAIL pre_reset_data: got %0d, expected 5", out_data);
    end
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_drain");
    step();
    rst = 1'b1;
    step();
    for (int i = 0; i < S; i++) exp_q.push_back('0);
    do_drain(1'b0);
    collect(S, 0, 1'b0);
  endtask

  initial begin
    a_in      = '0;
    a_valid   = 1'b0;
    sn        = 1'b0;
    b_in      = '0;
    drain     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_mac();
    test_restart();
    test_backpressure();
    test_overflow();
    test_ignore_rules();
    test_chaining();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
